// File: rtl/rf_writeback_ctrl.sv
// Register-file writeback controller: merges ALU/memory completions into a small FIFO,
// drains one write per cycle, and keeps a pending scoreboard. Optional bypass: RF_WB_BYPASS_EN.
module rf_writeback_ctrl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_dest,
  output logic              rsv_ready,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic              stall,
  input  logic              c0_valid,
  input  logic [ADDR_W-1:0] c0_dest,
  input  logic [DATA_W-1:0] c0_data,
  output logic              c0_ready,
  input  logic              c1_valid,
  input  logic [ADDR_W-1:0] c1_dest,
  input  logic [DATA_W-1:0] c1_data,
  output logic              c1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_dest,
  output logic [DATA_W-1:0] wr_val,
  output logic              byp1_hit,
  output logic              byp2_hit,
  output logic [DATA_W-1:0] byp1_val,
  output logic [DATA_W-1:0] byp2_val
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL_M2 = CNT_W'(DEPTH - 2);

  logic [NREG-1:0]   pending, pending_nxt;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, c1_slot;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] mem_dest [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic c0_acc, c1_acc, c0_enq, c1_enq, rsv_acc;

  assign c0_ready = count < CNT_FULL;
  assign c1_ready = count <= CNT_FULL_M2;
  assign c0_acc   = c0_valid && c0_ready;
  assign c1_acc   = c1_valid && c1_ready;
  // Writes to r0 are acknowledged but never occupy a slot.
  assign c0_enq   = c0_acc && (c0_dest != '0);
  assign c1_enq   = c1_acc && (c1_dest != '0);
  assign c1_slot  = c0_enq ? wr_ptr + PTR_W'(1) : wr_ptr;

  assign wr_en   = count != '0;
  assign wr_dest = wr_en ? mem_dest[rd_ptr] : '0;
  assign wr_val  = wr_en ? mem_data[rd_ptr] : '0;

  assign rsv_ready = !pending[rsv_dest] || (rsv_dest == '0);
  assign rsv_acc   = rsv_valid && rsv_ready;

  // Clear of the draining register happens before the new reservation is applied.
  always_comb begin
    pending_nxt = pending;
    if (wr_en)
      pending_nxt[wr_dest] = 1'b0;
    if (rsv_acc)
      pending_nxt[rsv_dest] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      pending <= pending_nxt;
      count   <= count - CNT_W'(wr_en) + CNT_W'(c0_enq) + CNT_W'(c1_enq);
      rd_ptr  <= rd_ptr + PTR_W'(wr_en);
      wr_ptr  <= wr_ptr + PTR_W'(c0_enq) + PTR_W'(c1_enq);
    end
  end

  // FIFO storage carries no reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (c0_enq) begin
      mem_dest[wr_ptr] <= c0_dest;
      mem_data[wr_ptr] <= c0_data;
    end
    if (c1_enq) begin
      mem_dest[c1_slot] <= c1_dest;
      mem_data[c1_slot] <= c1_data;
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign byp1_hit = wr_en && (wr_dest == src1) && (src1 != '0);
  assign byp2_hit = wr_en && (wr_dest == src2) && (src2 != '0);
  assign byp1_val = wr_val;
  assign byp2_val = wr_val;
  assign stall    = (pending[src1] && !byp1_hit) || (pending[src2] && !byp2_hit);
`else
  assign byp1_hit = 1'b0;
  assign byp2_hit = 1'b0;
  assign byp1_val = '0;
  assign byp2_val = '0;
  assign stall    = pending[src1] || pending[src2];
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_rf_writeback_ctrl;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, rsv_valid, rsv_ready, stall;
  logic [ADDR_W-1:0] rsv_dest, src1, src2, c0_dest, c1_dest, wr_dest;
  logic              c0_valid, c0_ready, c1_valid, c1_ready, wr_en;
  logic [DATA_W-1:0] c0_data, c1_data, wr_val, byp1_val, byp2_val;
  logic              byp1_hit, byp2_hit;

  rf_writeback_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .rsv_valid(rsv_valid), .rsv_dest(rsv_dest), .rsv_ready(rsv_ready),
    .src1(src1), .src2(src2), .stall(stall),
    .c0_valid(c0_valid), .c0_dest(c0_dest), .c0_data(c0_data), .c0_ready(c0_ready),
    .c1_valid(c1_valid), .c1_dest(c1_dest), .c1_data(c1_data), .c1_ready(c1_ready),
    .wr_en(wr_en), .wr_dest(wr_dest), .wr_val(wr_val),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp1_val(byp1_val), .byp2_val(byp2_val)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: queued {dest,data} writes and the set of reserved registers.
  logic [ADDR_W+DATA_W-1:0] ref_q[$];
  logic [31:0]              ref_pend;
  logic                     acc0, acc1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic settle();
    logic [ADDR_W+DATA_W-1:0] head;
    logic              e_en, e_h1, e_h2, e_stall;
    logic [ADDR_W-1:0] e_dest;
    logic [DATA_W-1:0] e_val;
    #2;
    e_en   = ref_q.size() != 0;
    head   = e_en ? ref_q[0] : '0;
    e_dest = head[DATA_W +: ADDR_W];
    e_val  = head[DATA_W-1:0];
`ifdef RF_WB_BYPASS_EN
    e_h1 = e_en && (e_dest == src1) && (src1 != 0);
    e_h2 = e_en && (e_dest == src2) && (src2 != 0);
    check("byp1_val", byp1_val, e_val);
    check("byp2_val", byp2_val, e_val);
`else
    e_h1 = 1'b0;
    e_h2 = 1'b0;
    check("byp1_val", byp1_val, '0);
    check("byp2_val", byp2_val, '0);
`endif
    e_stall = (ref_pend[src1] && !e_h1) || (ref_pend[src2] && !e_h2);
    check("wr_en", wr_en, e_en);
    check("wr_dest", wr_dest, e_dest);
    check("wr_val", wr_val, e_val);
    check("byp1_hit", byp1_hit, e_h1);
    check("byp2_hit", byp2_hit, e_h2);
    check("stall", stall, e_stall);
    check("rsv_ready", rsv_ready, !ref_pend[rsv_dest] || rsv_dest == 0);
    check("c0_ready", c0_ready, ref_q.size() < DEPTH);
    check("c1_ready", c1_ready, ref_q.size() <= DEPTH - 2);
  endtask

  task automatic adv();
    int   sz;
    logic rsv_ok;
    logic [ADDR_W+DATA_W-1:0] head;
    sz = ref_q.size();
    if (rst) begin
      ref_q.delete();
      ref_pend = '0;
      acc0 = 1'b0;
      acc1 = 1'b0;
    end else begin
      acc0   = c0_valid && (sz < DEPTH);
      acc1   = c1_valid && (sz <= DEPTH - 2);
      rsv_ok = rsv_valid && (!ref_pend[rsv_dest] || rsv_dest == 0);
      if (sz != 0) begin
        head = ref_q.pop_front();
        ref_pend[head[DATA_W +: ADDR_W]] = 1'b0;
      end
      if (acc0 && c0_dest != 0) ref_q.push_back({c0_dest, c0_data});
      if (acc1 && c1_dest != 0) ref_q.push_back({c1_dest, c1_data});
      if (rsv_ok) ref_pend[rsv_dest] = 1'b1;
      ref_pend[0] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic idle();
    rst = 1'b0; rsv_valid = 1'b0; rsv_dest = '0; src1 = '0; src2 = '0;
    c0_valid = 1'b0; c0_dest = '0; c0_data = '0;
    c1_valid = 1'b0; c1_dest = '0; c1_data = '0;
  endtask

  task automatic do_reset(input int n);
    idle();
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    ref_pend = '0; acc0 = 1'b0; acc1 = 1'b0;
    idle();
    @(posedge clk); #1;
    do_reset(2);

    // Reset state and basic write
    settle();
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_dest", wr_dest, 5'd0);
    check("rst_wr_val", wr_val, 32'h0);
    rsv_valid = 1'b1; rsv_dest = 5'd5;
    adv();
    rsv_valid = 1'b0;
    c0_valid = 1'b1; c0_dest = 5'd5; c0_data = 32'hDEADBEEF; src1 = 5'd5;
    settle();
    check("basic_stall_N", stall, 1'b1);
    adv();
    c0_valid = 1'b0;
    settle();
    check("basic_wr_en", wr_en, 1'b1);
    check("basic_wr_dest", wr_dest, 5'd5);
    check("basic_wr_val", wr_val, 32'hDEADBEEF);
`ifdef RF_WB_BYPASS_EN
    check("basic_stall_N1", stall, 1'b0);
`else
    check("basic_stall_N1", stall, 1'b1);
`endif
    adv();
    settle();
    check("basic_wr_en_N2", wr_en, 1'b0);
    check("basic_stall_N2", stall, 1'b0);
    adv();

    // Ordering of simultaneous completions
    idle();
    c0_valid = 1'b1; c0_dest = 5'd1; c0_data = 32'h11;
    c1_valid = 1'b1; c1_dest = 5'd2; c1_data = 32'h22;
    tick();
    idle();
    settle();
    check("ord_first_dest", wr_dest, 5'd1);
    check("ord_first_val", wr_val, 32'h11);
    adv();
    settle();
    check("ord_second_dest", wr_dest, 5'd2);
    check("ord_second_val", wr_val, 32'h22);
    adv();
    settle();
    check("ord_empty", wr_en, 1'b0);
    adv();

    // WAW on r7 and r0 handling
    rsv_valid = 1'b1; rsv_dest = 5'd7;
    tick();
    settle();
    check("waw_refused", rsv_ready, 1'b0);
    adv();
    c0_valid = 1'b1; c0_dest = 5'd7; c0_data = 32'h77;
    tick();
    c0_valid = 1'b0;
    settle();
    check("waw_draining_wr", wr_dest, 5'd7);
    check("waw_still_refused", rsv_ready, 1'b0);
    adv();
    settle();
    check("waw_ready_after", rsv_ready, 1'b1);
    adv();
    rsv_valid = 1'b1; rsv_dest = 5'd0;
    settle();
    check("r0_rsv_ready", rsv_ready, 1'b1);
    adv();
    rsv_valid = 1'b0;
    c0_valid = 1'b1; c0_dest = 5'd0; c0_data = 32'h1;
    tick();
    c0_valid = 1'b0;
    settle();
    check("r0_no_write", wr_en, 1'b0);
    adv();

    // Reset mid-operation
    do_reset(1);
    rsv_valid = 1'b1; rsv_dest = 5'd3;
    tick();
    rsv_dest = 5'd4;
    tick();
    rsv_valid = 1'b0;
    c0_valid = 1'b1; c0_dest = 5'd10; c0_data = 32'hA0;
    c1_valid = 1'b1; c1_dest = 5'd11; c1_data = 32'hB0;
    tick();
    c0_dest = 5'd12; c1_dest = 5'd13;
    tick();
    idle();
    src1 = 5'd3; src2 = 5'd4;
    settle();
    check("mid_pre_stall", stall, 1'b1);
    check("mid_pre_c1_ready", c1_ready, 1'b0);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    settle();
    check("mid_wr_en", wr_en, 1'b0);
    check("mid_c1_ready", c1_ready, 1'b1);
    for (int s = 0; s < 32; s++) begin
      src1 = 5'(s); src2 = 5'(31 - s);
      #1;
      check("mid_stall_clear", stall, 1'b0);
    end
    src1 = '0; src2 = '0;
    adv();

    // Bypass of a draining value
    rsv_valid = 1'b1; rsv_dest = 5'd9;
    tick();
    rsv_valid = 1'b0;
    c0_valid = 1'b1; c0_dest = 5'd9; c0_data = 32'h55;
    tick();
    c0_valid = 1'b0; src1 = 5'd9;
    settle();
    check("byp_wr_dest", wr_dest, 5'd9);
`ifdef RF_WB_BYPASS_EN
    check("byp_hit", byp1_hit, 1'b1);
    check("byp_val", byp1_val, 32'h55);
    check("byp_stall", stall, 1'b0);
`else
    check("byp_hit", byp1_hit, 1'b0);
    check("byp_stall", stall, 1'b1);
`endif
    adv();

    // Randomized traffic; sources hold until accepted
    idle();
    acc0 = 1'b0; acc1 = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!c0_valid || acc0) begin
        c0_valid = ($urandom_range(0, 3) != 0);
        c0_dest  = 5'($urandom_range(0, 15));
        c0_data  = $urandom;
      end
      if (!c1_valid || acc1) begin
        c1_valid = ($urandom_range(0, 3) != 0);
        c1_dest  = 5'($urandom_range(0, 15));
        c1_data  = $urandom;
      end
      rsv_valid = ($urandom_range(0, 1) != 0);
      rsv_dest  = 5'($urandom_range(0, 15));
      src1      = 5'($urandom_range(0, 15));
      src2      = 5'($urandom_range(0, 15));
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end
    idle();
    repeat (DEPTH + 2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
